// File: rtl/riscv_structures.sv
// Shared pipeline packet types and RV32 funct3 load/store encodings.
// Latency: none (types only); backpressure: not applicable.
package riscv_structures;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic        mem_write;
        logic        mem_read;
        logic        reg_write;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } ex_to_mem_s;

    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_to_wb_s;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane select by byte offset plus sign/zero extension.
// Latency: combinational; backpressure: none.
module load_align
    import riscv_structures::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] wb_data
);

    logic [31:0] lane;

    assign lane = rdata >> {offset, 3'b000};

    always_comb begin
        wb_data = rdata;
        case (funct3)
            F3_LB:   wb_data = {{24{lane[7]}}, lane[7:0]};
            F3_LBU:  wb_data = {24'h0, lane[7:0]};
            F3_LH:   wb_data = {{16{lane[15]}}, lane[15:0]};
            F3_LHU:  wb_data = {16'h0, lane[15:0]};
            default: wb_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores to data memory, aligns load data, registers the writeback packet.
// Latency: ALU 1 cycle, store >=2, load >=3; stalls upstream while a request or response is outstanding.
module mem_stage
    import riscv_structures::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ex_to_mem_s        ex_to_mem,
    input  logic              ex_valid,
    output logic              mem_stall,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_req_addr,
    output logic [31:0]       dmem_req_wdata,
    output logic [3:0]        dmem_req_be,
    input  logic              dmem_rsp_valid,
    input  logic [31:0]       dmem_rsp_rdata,
    output mem_to_wb_s        mem_to_wb,
    output logic              mem_to_wb_valid,
    output logic              misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        is_mem, is_store, mis_c, accept, start;
    logic [1:0]  off;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, load_data;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    assign is_mem   = ex_to_mem.mem_read | ex_to_mem.mem_write;
    assign is_store = ex_to_mem.mem_write;
    assign off      = ex_to_mem.alu_result[1:0];
    // funct3[1:0]: 00 byte, 01 half, anything else behaves as a word access
    assign mis_c    = is_mem & (((ex_to_mem.funct3[1:0] == 2'b01) & off[0]) |
                                (ex_to_mem.funct3[1] & (off != 2'b00)));
    assign accept   = (state_q == S_IDLE) & ex_valid;
    assign start    = accept & is_mem & ~mis_c;

    assign mem_stall      = (state_q != S_IDLE) | start;
    assign dmem_req_valid = (state_q == S_REQ);

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = 32'h0;
        if (is_store) begin
            case (ex_to_mem.funct3)
                F3_SB: begin
                    be_c    = 4'b0001 << off;
                    wdata_c = {4{ex_to_mem.write_data[7:0]}};
                end
                F3_SH: begin
                    be_c    = 4'b0011 << off;
                    wdata_c = {2{ex_to_mem.write_data[15:0]}};
                end
                default: wdata_c = ex_to_mem.write_data;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_REQ;
            S_REQ:  if (dmem_req_ready) state_d = dmem_req_we ? S_IDLE : S_WAIT;
            S_WAIT: if (dmem_rsp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    load_align u_load_align (
        .rdata   (dmem_rsp_rdata),
        .offset  (off_q),
        .funct3  (f3_q),
        .wb_data (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req_we     <= 1'b0;
            dmem_req_addr   <= '0;
            dmem_req_wdata  <= '0;
            dmem_req_be     <= '0;
            rd_q            <= '0;
            rw_q            <= 1'b0;
            f3_q            <= '0;
            off_q           <= '0;
            mem_to_wb       <= '0;
            mem_to_wb_valid <= 1'b0;
            misaligned      <= 1'b0;
        end else begin
            mem_to_wb_valid <= 1'b0;
            misaligned      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept && !is_mem) begin
                        mem_to_wb       <= '{ex_to_mem.alu_result, ex_to_mem.rd,
                                             ex_to_mem.reg_write & (ex_to_mem.rd != 5'd0)};
                        mem_to_wb_valid <= 1'b1;
                    end else if (accept && mis_c) begin
                        mem_to_wb       <= '{ex_to_mem.alu_result, ex_to_mem.rd, 1'b0};
                        mem_to_wb_valid <= 1'b1;
                        misaligned      <= 1'b1;
                    end else if (start) begin
                        // request fields are frozen here and held until the handshake
                        dmem_req_we    <= is_store;
                        dmem_req_addr  <= ADDR_W'({ex_to_mem.alu_result[31:2], 2'b00});
                        dmem_req_wdata <= wdata_c;
                        dmem_req_be    <= be_c;
                        rd_q           <= ex_to_mem.rd;
                        rw_q           <= ex_to_mem.reg_write & ~is_store & (ex_to_mem.rd != 5'd0);
                        f3_q           <= ex_to_mem.funct3;
                        off_q          <= off;
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready && dmem_req_we) begin
                        mem_to_wb       <= '{32'h0, rd_q, 1'b0};
                        mem_to_wb_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (dmem_rsp_valid) begin
                        mem_to_wb       <= '{load_data, rd_q, rw_q};
                        mem_to_wb_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a queue scoreboard of expected writeback packets.
module tb_mem_stage;
    import riscv_structures::*;

    logic        clk = 1'b0;
    logic        rst_n;
    ex_to_mem_s  ex_to_mem;
    logic        ex_valid;
    logic        mem_stall;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_we;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    mem_to_wb_s  mem_to_wb;
    logic        mem_to_wb_valid, misaligned;

    typedef struct {
        mem_to_wb_s pkt;
        bit         chk_data;
        bit         mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .ex_to_mem(ex_to_mem), .ex_valid(ex_valid),
        .mem_stall(mem_stall), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_be(dmem_req_be), .dmem_rsp_valid(dmem_rsp_valid),
        .dmem_rsp_rdata(dmem_rsp_rdata), .mem_to_wb(mem_to_wb),
        .mem_to_wb_valid(mem_to_wb_valid), .misaligned(misaligned)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ex_to_mem_s mk(input logic [31:0] a, input logic [31:0] wd,
                                      input logic mw, input logic mr, input logic rw,
                                      input logic [4:0] rd, input logic [2:0] f3);
        mk = '{a, wd, mw, mr, rw, rd, f3};
    endfunction

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                        input bit cd, input bit mis);
        exp_t e;
        e.pkt = '{d, rd, rw};
        e.chk_data = cd;
        e.mis = mis;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a packet, compare against the queue head, then confirm it lasts one cycle.
    task automatic wait_pkt(input string tag);
        exp_t e;
        int   n = 0;
        while (!mem_to_wb_valid && n < 10) begin
            step();
            n++;
        end
        if (!mem_to_wb_valid) begin
            chk({tag, "_timeout"}, 64'(mem_to_wb_valid), 64'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        if (e.chk_data) chk({tag, "_data"}, 64'(mem_to_wb.wb_data), 64'(e.pkt.wb_data));
        chk({tag, "_rd"}, 64'(mem_to_wb.rd), 64'(e.pkt.rd));
        chk({tag, "_rw"}, 64'(mem_to_wb.reg_write), 64'(e.pkt.reg_write));
        chk({tag, "_mis"}, 64'(misaligned), 64'(e.mis));
        step();
        chk({tag, "_one_cycle"}, 64'(mem_to_wb_valid), 64'd0);
    endtask

    task automatic issue(input ex_to_mem_s e, input logic exp_stall, input string tag);
        ex_to_mem = e;
        ex_valid  = 1'b1;
        #1;
        chk({tag, "_stall_accept"}, 64'(mem_stall), 64'(exp_stall));
        step();
        ex_valid  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(dmem_req_valid), 64'd0);
        chk({tag, "_wb_valid"}, 64'(mem_to_wb_valid), 64'd0);
        chk({tag, "_mis"}, 64'(misaligned), 64'd0);
        chk({tag, "_wb"}, 64'(mem_to_wb), 64'd0);
        chk({tag, "_stall"}, 64'(mem_stall), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_to_mem = '0;
        ex_valid = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        #3;
        check_idle_outputs("reset");
        step();
        step();
        rst_n = 1'b1;
        step();

        // ALU op passes straight through in one cycle
        push(32'h1234, 5'd5, 1'b1, 1'b1, 1'b0);
        issue(mk(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 3'b000), 1'b0, "alu");
        chk("alu_stall_after", 64'(mem_stall), 64'd0);
        wait_pkt("alu");

        // ALU op to x0 must not write
        push(32'h55, 5'd0, 1'b0, 1'b1, 1'b0);
        issue(mk(32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 3'b000), 1'b0, "alu_x0");
        wait_pkt("alu_x0");

        // SB to 0x103
        issue(mk(32'h103, 32'hAABBCCDD, 1'b1, 1'b0, 1'b1, 5'd7, F3_SB), 1'b1, "sb");
        chk("sb_req_valid", 64'(dmem_req_valid), 64'd1);
        chk("sb_we", 64'(dmem_req_we), 64'd1);
        chk("sb_addr", 64'(dmem_req_addr), 64'h100);
        chk("sb_be", 64'(dmem_req_be), 64'b1000);
        chk("sb_wdata", 64'(dmem_req_wdata), 64'hDDDDDDDD);
        chk("sb_stall", 64'(mem_stall), 64'd1);
        dmem_req_ready = 1'b1;
        push(32'h0, 5'd7, 1'b0, 1'b0, 1'b0);
        step();
        dmem_req_ready = 1'b0;
        wait_pkt("sb");

        // SH at offset 2
        issue(mk(32'h202, 32'h11223344, 1'b1, 1'b0, 1'b0, 5'd8, F3_SH), 1'b1, "sh");
        chk("sh_be", 64'(dmem_req_be), 64'b1100);
        chk("sh_wdata", 64'(dmem_req_wdata), 64'h33443344);
        dmem_req_ready = 1'b1;
        push(32'h0, 5'd8, 1'b0, 1'b0, 1'b0);
        step();
        dmem_req_ready = 1'b0;
        wait_pkt("sh");

        // LB / LBU at offset 2 and LHU at offset 2 to x0
        for (int k = 0; k < 3; k++) begin
            logic [2:0]  f3;
            logic [31:0] rdat, expd;
            logic [4:0]  rd;
            f3   = (k == 0) ? F3_LB : (k == 1) ? F3_LBU : F3_LHU;
            rdat = (k == 2) ? 32'hBEEF0000 : 32'h00800000;
            expd = (k == 0) ? 32'hFFFFFF80 : (k == 1) ? 32'h00000080 : 32'h0000BEEF;
            rd   = (k == 2) ? 5'd0 : 5'd3;
            issue(mk(32'h202, 32'h0, 1'b0, 1'b1, 1'b1, rd, f3), 1'b1, "ld");
            chk("ld_we", 64'(dmem_req_we), 64'd0);
            chk("ld_be", 64'(dmem_req_be), 64'hF);
            dmem_req_ready = 1'b1;
            step();
            dmem_req_ready = 1'b0;
            dmem_rsp_valid = 1'b1;
            dmem_rsp_rdata = rdat;
            push(expd, rd, (rd != 5'd0), 1'b1, 1'b0);
            step();
            dmem_rsp_valid = 1'b0;
            wait_pkt("ld");
        end

        // LW with ready held low for 3 cycles, response 2 cycles after handshake
        issue(mk(32'h40C, 32'h0, 1'b0, 1'b1, 1'b1, 5'd10, F3_LW), 1'b1, "lw");
        for (int i = 0; i < 3; i++) begin
            chk("lw_hold_valid", 64'(dmem_req_valid), 64'd1);
            chk("lw_hold_addr", 64'(dmem_req_addr), 64'h40C);
            chk("lw_hold_be", 64'(dmem_req_be), 64'hF);
            chk("lw_hold_we", 64'(dmem_req_we), 64'd0);
            chk("lw_hold_stall", 64'(mem_stall), 64'd1);
            step();
        end
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("lw_wait_stall", 64'(mem_stall), 64'd1);
            chk("lw_wait_novalid", 64'(mem_to_wb_valid), 64'd0);
            step();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h12345678;
        push(32'h12345678, 5'd10, 1'b1, 1'b1, 1'b0);
        step();
        dmem_rsp_valid = 1'b0;
        wait_pkt("lw");

        // Stray response in IDLE is ignored
        dmem_rsp_valid = 1'b1;
        step();
        dmem_rsp_valid = 1'b0;
        chk("stray_rsp_novalid", 64'(mem_to_wb_valid), 64'd0);

        // Misaligned LH at 0x101
        push(32'h0, 5'd9, 1'b0, 1'b0, 1'b1);
        issue(mk(32'h101, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, F3_LH), 1'b0, "mis_lh");
        chk("mis_lh_no_req", 64'(dmem_req_valid), 64'd0);
        wait_pkt("mis_lh");
        chk("mis_lh_pulse_end", 64'(misaligned), 64'd0);

        // Misaligned SW at 0x102
        push(32'h0, 5'd4, 1'b0, 1'b0, 1'b1);
        issue(mk(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 5'd4, F3_SW), 1'b0, "mis_sw");
        chk("mis_sw_no_req", 64'(dmem_req_valid), 64'd0);
        wait_pkt("mis_sw");

        // Reset during WAIT, then a late response
        issue(mk(32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, F3_LW), 1'b1, "rst_lw");
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        chk("rst_in_wait_stall", 64'(mem_stall), 64'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        step();
        rst_n = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'hDEADBEEF;
        step();
        dmem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_idle_outputs("rst_late_rsp");
            step();
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
